// File: rtl/wave_pattern_pkg.sv
// Shared types and defaults for the wave pattern sequencer.
// Optional edge-flag outputs on the top are enabled with WAVE_EDGE_FLAGS_EN.
package wave_pattern_pkg;

    localparam int WPG_DEPTH  = 8;
    localparam int WPG_B_W    = 4;
    localparam int WPG_HOLD_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    // Table entry layout; the register file stores entries as {hold, a, b}.
    typedef struct packed {
        logic [WPG_HOLD_W-1:0] hold;
        logic                  a;
        logic [WPG_B_W-1:0]    b;
    } step_t;

endpackage

// File: rtl/wave_step_table.sv
// DEPTH x W step register file: synchronous write, asynchronous read,
// asynchronous clear on reset.
module wave_step_table #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wave_pattern_gen.sv
// Programmable a/b waveform sequencer playing a stored step table.
// Define WAVE_EDGE_FLAGS_EN to add the a_rise/a_fell edge-flag outputs.
module wave_pattern_gen
    import wave_pattern_pkg::*;
#(
    parameter int DEPTH  = WPG_DEPTH,
    parameter int B_W    = WPG_B_W,
    parameter int HOLD_W = WPG_HOLD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic                       wr_a,
    input  logic [B_W-1:0]             wr_b,
    input  logic [HOLD_W-1:0]          wr_hold,
    input  logic [$clog2(DEPTH+1)-1:0] num_steps,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       a_out,
    output logic [B_W-1:0]             b_out
`ifdef WAVE_EDGE_FLAGS_EN
    ,
    output logic                       a_rise,
    output logic                       a_fell
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int EW = HOLD_W + 1 + B_W;

    state_e            state_q, state_d;
    logic [SW-1:0]     steps_q, steps_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              a_q, a_d;
    logic [B_W-1:0]    b_q, b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;

    logic [AW-1:0]     rd_addr;
    logic [EW-1:0]     rd_data;
    logic [HOLD_W-1:0] rd_hold;
    logic              rd_a;
    logic [B_W-1:0]    rd_b;
    logic [SW-1:0]     steps_in;
    logic              is_last;
    logic              tbl_wr;

    assign tbl_wr = wr_en && (state_q == IDLE);

    wave_step_table #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tbl_wr),
        .wr_addr (wr_addr),
        .wr_data ({wr_hold, wr_a, wr_b}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_hold  = rd_data[EW-1 -: HOLD_W];
    assign rd_a     = rd_data[B_W];
    assign rd_b     = rd_data[B_W-1:0];
    assign steps_in = (num_steps > SW'(DEPTH)) ? SW'(DEPTH) : num_steps;
    assign is_last  = (SW'(idx_q) == steps_q - SW'(1));

    // Single read port: points at the next step while playing, else entry 0
    // (also covers start and loop wrap).
    assign rd_addr = (state_q == PLAY && !is_last) ? idx_q + AW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            steps_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (steps_in != '0) begin
                        state_d = PLAY;
                        steps_d = steps_in;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        load    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end else if (!is_last) begin
                    idx_d = idx_q + AW'(1);
                    load  = 1'b1;
                end else if (loop_en) begin
                    idx_d = '0;
                    load  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            a_d   = rd_a;
            b_d   = rd_b;
            cnt_d = rd_hold;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = idx_q;
    assign a_out    = a_q;
    assign b_out    = b_q;

`ifdef WAVE_EDGE_FLAGS_EN
    logic a_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_prev <= 1'b0;
        end else begin
            a_prev <= a_q;
        end
    end

    assign a_rise = a_q & ~a_prev;
    assign a_fell = ~a_q & a_prev;
`endif

endmodule

// File: tb/tb_wave_pattern_gen.sv
// Self-checking bench for wave_pattern_gen: directed vector table, hand
// sequences and randomized runs against a step-list reference model.
module tb_wave_pattern_gen;
    import wave_pattern_pkg::*;

    localparam int DEPTH  = 8;
    localparam int B_W    = 4;
    localparam int HOLD_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_addr = '0;
    logic              wr_a = 1'b0;
    logic [B_W-1:0]    wr_b = '0;
    logic [HOLD_W-1:0] wr_hold = '0;
    logic [3:0]        num_steps = '0;
    logic              loop_en = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              busy, done, a_out;
    logic [2:0]        step_idx;
    logic [B_W-1:0]    b_out;
`ifdef WAVE_EDGE_FLAGS_EN
    logic              a_rise, a_fell;
`endif

    always #5 clk = ~clk;

    wave_pattern_gen #(
        .DEPTH  (DEPTH),
        .B_W    (B_W),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_a      (wr_a),
        .wr_b      (wr_b),
        .wr_hold   (wr_hold),
        .num_steps (num_steps),
        .loop_en   (loop_en),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx),
        .a_out     (a_out),
        .b_out     (b_out)
`ifdef WAVE_EDGE_FLAGS_EN
        ,
        .a_rise    (a_rise),
        .a_fell    (a_fell)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: table contents and last visible outputs.
    step_t shadow [DEPTH];
    logic       last_a;
    logic [3:0] last_b;
    int         last_idx;

    typedef struct {
        int         idx;
        logic       a;
        logic [3:0] b;
    } obs_t;
    obs_t exp_q[$];

    typedef struct {
        logic       start;
        logic       stop;
        logic       loop;
        logic       busy;
        logic       done;
        int         idx;
        logic       a;
        logic [3:0] b;
    } vec_t;
    vec_t vecs [18];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic a, input logic [3:0] b, input logic [3:0] hold);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_a    = a;
        wr_b    = b;
        wr_hold = hold;
        tick();
        wr_en = 1'b0;
        shadow[addr] = '{hold: hold, a: a, b: b};
    endtask

    // Expected trace: each of min(n, DEPTH) steps repeated hold+1 times.
    task automatic play_check(input int n, input bit poke);
        int eff;
        int poke_at;
        eff = (n > DEPTH) ? DEPTH : n;
        exp_q.delete();
        for (int s = 0; s < eff; s++)
            for (int h = 0; h <= int'(shadow[s].hold); h++)
                exp_q.push_back('{s, shadow[s].a, shadow[s].b});
        num_steps = 4'(n);
        loop_en   = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (eff == 0) begin
            chk("zero_done", int'(done), 1);
            chk("zero_busy", int'(busy), 0);
            chk("zero_a", int'(a_out), int'(last_a));
            chk("zero_b", int'(b_out), int'(last_b));
            tick();
            chk("zero_done_clr", int'(done), 0);
            return;
        end
        poke_at = poke ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
        foreach (exp_q[k]) begin
            chk($sformatf("run_busy[%0d]", k), int'(busy), 1);
            chk($sformatf("run_done[%0d]", k), int'(done), 0);
            chk($sformatf("run_idx[%0d]", k), int'(step_idx), exp_q[k].idx);
            chk($sformatf("run_a[%0d]", k), int'(a_out), int'(exp_q[k].a));
            chk($sformatf("run_b[%0d]", k), int'(b_out), int'(exp_q[k].b));
            if (k == poke_at) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_a    = ~shadow[0].a;
                wr_b    = ~shadow[0].b;
                wr_hold = ~shadow[0].hold;
            end
            tick();
            wr_en = 1'b0;
        end
        last_a   = shadow[eff-1].a;
        last_b   = shadow[eff-1].b;
        last_idx = eff - 1;
        chk("end_busy", int'(busy), 0);
        chk("end_done", int'(done), 1);
        chk("end_idx", int'(step_idx), last_idx);
        chk("end_a", int'(a_out), int'(last_a));
        chk("end_b", int'(b_out), int'(last_b));
        tick();
        chk("end_done_clr", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // start stop loop | busy done idx a b
        vecs[0]  = '{1, 0, 0, 1, 0, 0, 0, 4'h4};
        vecs[1]  = '{0, 0, 0, 1, 0, 0, 0, 4'h4};
        vecs[2]  = '{0, 0, 0, 1, 0, 1, 1, 4'h5};
        vecs[3]  = '{0, 0, 0, 1, 0, 2, 0, 4'h0};
        vecs[4]  = '{0, 0, 0, 1, 0, 2, 0, 4'h0};
        vecs[5]  = '{0, 0, 0, 1, 0, 2, 0, 4'h0};
        vecs[6]  = '{0, 0, 0, 0, 1, 2, 0, 4'h0};
        vecs[7]  = '{0, 0, 0, 0, 0, 2, 0, 4'h0};
        vecs[8]  = '{1, 0, 1, 1, 0, 0, 0, 4'h4};
        vecs[9]  = '{0, 0, 1, 1, 0, 0, 0, 4'h4};
        vecs[10] = '{0, 0, 1, 1, 0, 1, 1, 4'h5};
        vecs[11] = '{0, 0, 1, 1, 0, 2, 0, 4'h0};
        vecs[12] = '{0, 0, 1, 1, 0, 2, 0, 4'h0};
        vecs[13] = '{0, 0, 1, 1, 0, 2, 0, 4'h0};
        vecs[14] = '{0, 0, 1, 1, 0, 0, 0, 4'h4};
        vecs[15] = '{0, 1, 1, 0, 0, 0, 0, 4'h4};
        vecs[16] = '{0, 0, 1, 0, 0, 0, 0, 4'h4};
        vecs[17] = '{0, 0, 1, 0, 0, 0, 0, 4'h4};

        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        last_a = 1'b0; last_b = '0; last_idx = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(step_idx), 0);
        chk("rst_a", int'(a_out), 0);
        chk("rst_b", int'(b_out), 0);
        #2 rst_n = 1'b1;
        tick();

        // Zero-step start: done pulse only
        play_check(0, 0);

        // start and stop together in IDLE: nothing happens
        num_steps = 4'd3; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", int'(busy), 0);
        chk("ss_done", int'(done), 0);
        tick();
        chk("ss_busy2", int'(busy), 0);

        // Directed table: one-shot run, then looping run aborted by stop
        wr(0, 1'b0, 4'h4, 4'd1);
        wr(1, 1'b1, 4'h5, 4'd0);
        wr(2, 1'b0, 4'h0, 4'd2);
        num_steps = 4'd3;
        for (int i = 0; i < 18; i++) begin
            start   = vecs[i].start;
            stop    = vecs[i].stop;
            loop_en = vecs[i].loop;
            tick();
            start = 1'b0; stop = 1'b0;
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].done));
            chk($sformatf("vec%0d_idx", i), int'(step_idx), vecs[i].idx);
            chk($sformatf("vec%0d_a", i), int'(a_out), int'(vecs[i].a));
            chk($sformatf("vec%0d_b", i), int'(b_out), int'(vecs[i].b));
        end
        loop_en = 1'b0;
        last_a = 1'b0; last_b = 4'h4; last_idx = 0;

        // Oversized num_steps clamps to DEPTH; write to e0 during play dropped
        for (int i = 0; i < DEPTH; i++)
            wr(i, 1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)));
        play_check(15, 1);
        play_check(15, 0);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++)
                wr(int'($urandom_range(0, DEPTH - 1)), 1'($urandom), 4'($urandom), 4'($urandom));
            play_check(int'($urandom_range(0, 10)), 1'($urandom));
        end

        // Asynchronous reset mid-step clears outputs and the table
        wr(0, 1'b1, 4'hA, 4'd5);
        num_steps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("pre_rst_a", int'(a_out), 1);
        chk("pre_rst_b", int'(b_out), 10);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_a", int'(a_out), 0);
        chk("arst_b", int'(b_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_idx", int'(step_idx), 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        last_a = 1'b0; last_b = '0; last_idx = 0;
        tick();
        play_check(3, 0);

`ifdef WAVE_EDGE_FLAGS_EN
        begin
            logic exp_r [5];
            logic exp_f [5];
            exp_r = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            exp_f = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            for (int i = 0; i < 4; i++) wr(i, 1'(i % 2), 4'(i), 4'd0);
            num_steps = 4'd4; start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 5; c++) begin
                chk($sformatf("rise%0d", c + 1), int'(a_rise), int'(exp_r[c]));
                chk($sformatf("fell%0d", c + 1), int'(a_fell), int'(exp_f[c]));
                tick();
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_pattern_gen.md
Name: wave_pattern_gen

Overview:
Programmable stimulus sequencer that plays a stored table of steps onto a 1-bit line (a_out) and a B_W-bit bus (b_out). Each step holds its values for a programmed number of clock cycles. It is the driving end of the single-bit/multi-bit sampled-signal checks: it produces the a/b waveforms that edge and sampled-value assertions observe. It sits in simulation benches and in on-chip self-test as a deterministic waveform source.

Parameters:
DEPTH, 8, number of table entries (power of two, >=2)
B_W, 4, width of b_out and table b field
HOLD_W, 4, width of per-step hold field (step lasts hold+1 cycles)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe
wr_addr  in  $clog2(DEPTH)  table entry index
wr_a  in  1  a value for entry
wr_b  in  B_W  b value for entry
wr_hold  in  HOLD_W  hold count for entry
num_steps  in  $clog2(DEPTH+1)  steps to play, latched on start
loop_en  in  1  restart at step 0 after last step
start  in  1  begin playback (pulse)
stop  in  1  abort playback (pulse)
busy  out  1  high while in PLAY
done  out  1  one-cycle pulse on normal completion
step_idx  out  $clog2(DEPTH)  index of step currently driven
a_out  out  1  waveform bit
b_out  out  B_W  waveform bus

Behaviour:
- One clock (clk); reset rst_n is asynchronous, active-low.
- Reset: table cleared to all zeros; a_out=0, b_out=0, busy=0, done=0, step_idx=0, hold counter=0, FSM=IDLE.
- Table write: on a clk edge with wr_en=1 and FSM=IDLE, entry[wr_addr] <= {wr_hold, wr_a, wr_b}. Writes while busy are dropped.
- FSM states: IDLE, PLAY.
- IDLE->PLAY: start=1, stop=0, latched steps>0. At that edge: latch steps=min(num_steps, DEPTH); step_idx<=0; a_out/b_out <= entry[0]; hold counter <= entry[0].hold; busy<=1. Outputs therefore change 1 cycle after start.
- start with num_steps=0: stay IDLE, done=1 for the next cycle, outputs unchanged.
- start and stop in the same IDLE cycle: stop wins, nothing happens.
- PLAY, counter>0: counter decrements; outputs held.
- PLAY, counter==0, step_idx<steps-1: step_idx+1; load that entry's values and hold.
- PLAY, counter==0, step_idx==steps-1:
  - loop_en=1 (sampled at that edge): wrap to step 0 with no gap cycle.
  - loop_en=0: go to IDLE; busy<=0; done=1 for one cycle; a_out/b_out/step_idx keep their last values.
- stop=1 in PLAY: at the next edge go to IDLE, busy<=0, no done pulse, outputs hold their current values. stop overrides a same-cycle step advance or completion.
- start while in PLAY is ignored.
- Each step is visible for exactly hold+1 cycles. Total non-loop playback = sum(hold_i+1) cycles.
- Reset asserted mid-playback: immediately returns to the reset values, including clearing the table.

Optional Feature:
- Macro: WAVE_EDGE_FLAGS_EN.
- When defined, adds output ports a_rise (1) and a_fell (1) and a register a_prev (reset 0), updated each cycle from a_out.
  - a_rise = a_out & ~a_prev; a_fell = ~a_out & a_prev. Both are aligned with the cycle in which a_out shows the new value, mirroring $rose/$fell on a_out.
  - The first 1 after reset produces a_rise.
- When not defined, these ports and a_prev do not exist, and behaviour is otherwise identical.

Decomposition:
- Package wave_pattern_pkg:
  - typedef enum state_e {IDLE, PLAY}
  - typedef struct packed step_t {hold, a, b}, parameterised via package localparams WPG_B_W=4 and WPG_HOLD_W=4
  - localparam WPG_DEPTH=8
- One natural sub-module: wave_step_table (DEPTH x step_t register file: sync write, async read, async clear).

Test Plan:
- Program entries {hold,a,b}: e0={1,0,4'h4}, e1={0,1,4'h5}, e2={2,0,4'h0}. num_steps=3, loop_en=0, start at cycle T -> from T+1: (a,b) = (0,4)x2, (1,5)x1, (0,0)x3; done=1 at T+7; busy high T+1..T+6.
- Same table with loop_en=1 -> after e2 returns to e0 with no gap. stop at cycle S -> busy=0 at S+1, outputs frozen, done never asserted.
- num_steps=0 with start -> done pulse 1 cycle later, busy stays 0, a_out=0, b_out=0.
- num_steps=15 with DEPTH=8 -> plays exactly 8 steps, then done. wr_en during PLAY to e0 -> the following run still shows the original e0 values.
- Assert rst_n=0 mid-step -> outputs=0 and busy=0 asynchronously; after release, start plays all-zero entries.
- WAVE_EDGE_FLAGS_EN defined, table a sequence 0,1,0,1 with hold=0 -> a_rise high in cycles 2 and 4 of playback, a_fell high in cycle 3, each for exactly one cycle.
